// File: rtl/oled_pkg.sv
// Shared definitions for the oledControl send-port arbiters.
package oled_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned NUM_REQ_DEF        = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2_000_000;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RELEASE
    } arb_state_e;

endpackage

// File: rtl/oled_send_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, lowest valid index at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] lo_win;
    logic [ID_W-1:0] hi_win;
    logic            hi_found;

    // Descending scans so the last hit is the lowest index of each half.
    always_comb begin
        lo_win   = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_win = ID_W'(j);
                if (ID_W'(j) >= rr_ptr) begin
                    hi_win   = ID_W'(j);
                    hi_found = 1'b1;
                end
            end
        end
        any    = |req_valid;
        winner = hi_found ? hi_win : lo_win;
    end

endmodule

// File: rtl/oled_send_arbiter.sv
// Message-granular round-robin arbiter in front of the oledControl byte-send port.
// Optional send timeout enabled by defining OLED_ARB_TIMEOUT_EN.
module oled_send_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned ID_W           = 3,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [BYTE_W-1:0]         sendData,
    output logic                      sendDataValid,
`ifdef OLED_ARB_TIMEOUT_EN
    output logic                      timeout_err,
`endif
    input  logic                      sendDone
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic              pick_any;
    logic [ID_W-1:0]   pick_win;
    logic [ID_W-1:0]   sel_id;
    logic [BYTE_W-1:0] sel_byte;
    logic              sel_valid;
    logic              sel_last;
    logic              ack_fire;
    logic              adv_ptr;

`ifdef OLED_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_err_q, tmo_err_d;
    logic        tmo_fire;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .any       (pick_any),
        .winner    (pick_win)
    );

    // Idle looks at the fresh winner; otherwise the owner's lane is the only one that matters.
    always_comb begin
        sel_id    = (state_q == ARB_IDLE) ? pick_win : grant_q;
        sel_byte  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_byte  = req_data[i*BYTE_W +: BYTE_W];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

`ifdef OLED_ARB_TIMEOUT_EN
    assign tmo_fire = (state_q != ARB_IDLE) && (tmo_cnt_q >= TIMEOUT_CYCLES - 1);
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        ack_fire = 1'b0;
        adv_ptr  = 1'b0;
`ifdef OLED_ARB_TIMEOUT_EN
        tmo_err_d = tmo_err_q;
`endif

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any && !sendDone) begin
                    grant_d = pick_win;
                    data_d  = sel_byte;
                    valid_d = 1'b1;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (sendDone) begin
                    valid_d  = 1'b0;
                    ack_fire = 1'b1;
                    last_d   = sel_last;
                    state_d  = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                // Hold off until oledControl has closed the previous handshake.
                if (!sendDone) begin
                    if (last_q) begin
                        adv_ptr = 1'b1;
                        state_d = ARB_IDLE;
                    end else if (sel_valid) begin
                        data_d  = sel_byte;
                        valid_d = 1'b1;
                        state_d = ARB_ISSUE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

`ifdef OLED_ARB_TIMEOUT_EN
        if (tmo_fire) begin
            valid_d   = 1'b0;
            ack_fire  = 1'b1;
            adv_ptr   = 1'b1;
            tmo_err_d = 1'b1;
            state_d   = ARB_IDLE;
        end
        tmo_cnt_d = (state_q == ARB_IDLE || state_d != state_q) ? '0 : tmo_cnt_q + 32'd1;
`endif

        if (adv_ptr) begin
            rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = ack_fire && (grant_q == ID_W'(i));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
        end
    end

`ifdef OLED_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`endif

    assign req_ack       = ack_q;
    assign busy          = (state_q != ARB_IDLE);
    assign grant_id      = grant_q;
    assign sendData      = data_q;
    assign sendDataValid = valid_q;

endmodule
